// File: rtl/node_pkg.sv
// Shared definitions for the primitive-recursive node family:
// the operation encodings and the sequencer state type.
package node_pkg;

    localparam int MODE_ZERO = 0;
    localparam int MODE_SUCC = 1;
    localparam int MODE_PROJ = 2;
    localparam int MODE_ADD  = 3;
    localparam int MODE_MUL  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } node_state_e;

endpackage

// File: rtl/node_start_det.sv
// Rising-edge detector on the start level. The previous sample is tracked
// through reset, so a level held high across reset never counts as an edge.
module node_start_det (
    input  logic CLK,
    input  logic RST,
    input  logic ST,
    output logic EDGE
);

    logic st_prev_d;
    logic st_prev_q;

    always_comb begin
        st_prev_d = ST;
    end

    always_ff @(posedge CLK) begin
        st_prev_q <= st_prev_d;
    end

    assign EDGE = ST & ~st_prev_q & ~RST;

endmodule

// File: rtl/node_prim.sv
// Primitive-recursive node: ZERO, SUCC, PROJ, ADD (iterated increment) and
// MUL (iterated addition) selected at elaboration, with a start/ready handshake.
module node_prim
    import node_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NIN   = 2,
    parameter int MODE  = MODE_ZERO,
    parameter int PSEL  = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ST,
    input  logic [NIN*WIDTH-1:0] IN,
    output logic                 RD,
    output logic [WIDTH-1:0]     RES,
    output logic                 OVF
);

    if (MODE < MODE_ZERO || MODE > MODE_MUL) begin : g_bad_mode
        $error("node_prim: illegal MODE %0d", MODE);
    end
    if (NIN < 2 || NIN > 8) begin : g_bad_nin
        $error("node_prim: illegal NIN %0d", NIN);
    end
    if (PSEL < 0 || PSEL >= NIN) begin : g_bad_psel
        $error("node_prim: illegal PSEL %0d", PSEL);
    end

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic start_edge;

    node_start_det u_start_det (
        .CLK  (CLK),
        .RST  (RST),
        .ST   (ST),
        .EDGE (start_edge)
    );

    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op_sel;

    assign op0    = IN[0 +: WIDTH];
    assign op1    = IN[WIDTH +: WIDTH];
    assign op_sel = IN[PSEL*WIDTH +: WIDTH];

    node_state_e      state_d, state_q;
    logic [WIDTH-1:0] acc_d, acc_q;
    logic [WIDTH-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] addend_d, addend_q;
    logic [WIDTH-1:0] res_d, res_q;
    logic             ovf_d, ovf_q;
    logic             wrap_d, wrap_q;
    logic [WIDTH:0]   step_sum;

    // One RUN iteration: MUL adds the latched multiplicand, ADD increments.
    always_comb begin
        if (MODE == MODE_MUL) begin
            step_sum = {1'b0, acc_q} + {1'b0, addend_q};
        end else begin
            step_sum = {1'b0, acc_q} + {1'b0, ONE};
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        addend_d = addend_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        wrap_d   = wrap_q;

        if (RST) begin
            state_d  = S_IDLE;
            acc_d    = '0;
            cnt_d    = '0;
            addend_d = '0;
            res_d    = '0;
            ovf_d    = 1'b0;
            wrap_d   = 1'b0;
        end else if (start_edge) begin
            // A start edge restarts from any state; RES keeps its old value.
            state_d  = S_DONE;
            ovf_d    = 1'b0;
            wrap_d   = 1'b0;
            cnt_d    = '0;
            addend_d = op0;
            case (MODE)
                MODE_ZERO: acc_d = '0;
                MODE_SUCC: {wrap_d, acc_d} = {1'b0, op0} + {1'b0, ONE};
                MODE_PROJ: acc_d = op_sel;
                MODE_ADD: begin
                    acc_d = op0;
                    cnt_d = op1;
                    if (op1 != '0) state_d = S_RUN;
                end
                default: begin
                    acc_d = '0;
                    cnt_d = op1;
                    if (op1 != '0) state_d = S_RUN;
                end
            endcase
        end else begin
            case (state_q)
                S_RUN: begin
                    acc_d  = step_sum[WIDTH-1:0];
                    wrap_d = wrap_q | step_sum[WIDTH];
                    cnt_d  = cnt_q - ONE;
                    if (cnt_q == ONE) state_d = S_DONE;
                end
                S_DONE: begin
                    res_d   = acc_q;
                    ovf_d   = wrap_q;
                    state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        state_q  <= state_d;
        acc_q    <= acc_d;
        cnt_q    <= cnt_d;
        addend_q <= addend_d;
        res_q    <= res_d;
        ovf_q    <= ovf_d;
        wrap_q   <= wrap_d;
    end

    assign RD  = (state_q == S_IDLE);
    assign RES = res_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_node_prim.sv
// Bench for node_prim: one instance per operation, directed corner cases plus
// randomized operations checked against an arithmetic model.
module tb_node_prim;
    import node_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic [4:0]  st;
    logic [4:0]  rd;
    logic [4:0]  ovf;
    logic [31:0] in_z, in_s, in_a;
    logic [47:0] in_p;
    logic [15:0] in_m;
    logic [15:0] res_z, res_s, res_p, res_a;
    logic [7:0]  res_m;

    int vectors     = 0;
    int miscompares = 0;

    node_prim #(.WIDTH(16), .NIN(2), .MODE(MODE_ZERO), .PSEL(0)) u_zero (
        .CLK(CLK), .RST(RST), .ST(st[0]), .IN(in_z), .RD(rd[0]), .RES(res_z), .OVF(ovf[0]));
    node_prim #(.WIDTH(16), .NIN(2), .MODE(MODE_SUCC), .PSEL(0)) u_succ (
        .CLK(CLK), .RST(RST), .ST(st[1]), .IN(in_s), .RD(rd[1]), .RES(res_s), .OVF(ovf[1]));
    node_prim #(.WIDTH(16), .NIN(3), .MODE(MODE_PROJ), .PSEL(2)) u_proj (
        .CLK(CLK), .RST(RST), .ST(st[2]), .IN(in_p), .RD(rd[2]), .RES(res_p), .OVF(ovf[2]));
    node_prim #(.WIDTH(16), .NIN(2), .MODE(MODE_ADD), .PSEL(0)) u_add (
        .CLK(CLK), .RST(RST), .ST(st[3]), .IN(in_a), .RD(rd[3]), .RES(res_a), .OVF(ovf[3]));
    node_prim #(.WIDTH(8), .NIN(2), .MODE(MODE_MUL), .PSEL(1)) u_mul (
        .CLK(CLK), .RST(RST), .ST(st[4]), .IN(in_m), .RD(rd[4]), .RES(res_m), .OVF(ovf[4]));

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] get_res(input int id);
        case (id)
            0:       return res_z;
            1:       return res_s;
            2:       return res_p;
            3:       return res_a;
            default: return {8'h00, res_m};
        endcase
    endfunction

    task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c);
        case (id)
            0:       in_z = {b, a};
            1:       in_s = {b, a};
            2:       in_p = {c, b, a};
            3:       in_a = {b, a};
            default: in_m = {b[7:0], a[7:0]};
        endcase
    endtask

    // Arithmetic reference: result, wrap flag and start-to-ready latency.
    task automatic model(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, output logic [15:0] er, output logic eo,
                         output int lat);
        longint s;
        case (id)
            0: begin er = 16'h0; eo = 1'b0; lat = 1; end
            1: begin
                s = longint'(a) + 1;
                er = 16'(s % 65536); eo = (s > 65535); lat = 1;
            end
            2: begin er = c; eo = 1'b0; lat = 1; end
            3: begin
                s = longint'(a) + longint'(b);
                er = 16'(s % 65536); eo = (s > 65535); lat = 1 + int'(b);
            end
            default: begin
                s = longint'(a[7:0]) * longint'(b[7:0]);
                er = 16'(s % 256); eo = (s > 255); lat = 1 + int'(b[7:0]);
            end
        endcase
    endtask

    task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input string tag);
        logic [15:0] er;
        logic [15:0] prev;
        logic        eo;
        logic        held;
        int          lat;
        int          n;
        model(id, a, b, c, er, eo, lat);
        set_ops(id, a, b, c);
        st[id] = 1'b0;
        tick();
        prev = get_res(id);
        st[id] = 1'b1;
        tick();
        chk({tag, "_busy"}, 32'(rd[id]), 32'd0);
        chk({tag, "_ovfclr"}, 32'(ovf[id]), 32'd0);
        st[id] = 1'b0;
        set_ops(id, 16'($urandom), 16'($urandom), 16'($urandom));
        n = 0;
        held = 1'b1;
        if (get_res(id) !== prev) held = 1'b0;
        while (n < 600) begin
            tick();
            n++;
            if (rd[id] === 1'b1) break;
            if (get_res(id) !== prev) held = 1'b0;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_res"}, 32'(get_res(id)), 32'(er));
        chk({tag, "_ovf"}, 32'(ovf[id]), 32'(eo));
        chk({tag, "_hold"}, 32'(held), 32'd1);
    endtask

    initial begin
        int          n;
        int          id;
        logic [15:0] a, b, c;

        RST  = 1'b1;
        st   = 5'b11111;
        in_z = '0; in_s = '0; in_a = '0; in_p = '0; in_m = '0;
        tick();
        tick();
        RST = 1'b0;
        chk("reset_rd", 32'(rd), 32'h1f);
        chk("reset_ovf", 32'(ovf), 32'h0);
        chk("reset_res_a", 32'(res_a), 32'h0);
        chk("reset_res_m", 32'(res_m), 32'h0);
        tick();
        tick();
        chk("held_st_no_start", 32'(rd), 32'h1f);
        st = 5'b00000;
        tick();

        do_op(0, 16'h1234, 16'h5678, 16'h0, "zero");
        do_op(1, 16'hFFFF, 16'h0, 16'h0, "succ_wrap");
        do_op(1, 16'h00FE, 16'h7, 16'h0, "succ");
        do_op(2, 16'h1111, 16'h2222, 16'hBEEF, "proj");
        do_op(3, 16'd5, 16'd3, 16'h0, "add_5_3");
        do_op(3, 16'd5, 16'd0, 16'h0, "add_cnt0");
        do_op(3, 16'hFFFE, 16'd4, 16'h0, "add_wrap");
        do_op(4, 16'd20, 16'd13, 16'h0, "mul_20_13");
        do_op(4, 16'd7, 16'd0, 16'h0, "mul_cnt0");
        do_op(4, 16'd9, 16'd5, 16'h0, "mul_9_5");

        // Restart mid-run: second edge three cycles after the first.
        set_ops(3, 16'd1, 16'd10, 16'h0);
        st[3] = 1'b0;
        tick();
        st[3] = 1'b1;
        tick();
        st[3] = 1'b0;
        tick();
        tick();
        set_ops(3, 16'd1, 16'd2, 16'h0);
        st[3] = 1'b1;
        tick();
        chk("restart_busy", 32'(rd[3]), 32'd0);
        st[3] = 1'b0;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (rd[3] === 1'b1) break;
        end
        chk("restart_lat", 32'(n), 32'd3);
        chk("restart_res", 32'(res_a), 32'd3);

        // Reset mid-run with ST held high throughout.
        set_ops(4, 16'd9, 16'd30, 16'h0);
        st[4] = 1'b0;
        tick();
        st[4] = 1'b1;
        tick();
        tick();
        tick();
        chk("mulrst_busy", 32'(rd[4]), 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mulrst_rd", 32'(rd[4]), 32'd1);
        chk("mulrst_res", 32'(res_m), 32'd0);
        chk("mulrst_ovf", 32'(ovf[4]), 32'd0);
        tick();
        tick();
        tick();
        chk("mulrst_no_retrigger", 32'(rd[4]), 32'd1);
        do_op(4, 16'd16, 16'd17, 16'h0, "mul_after_rst");

        for (int i = 0; i < 14; i++) begin
            id = int'($urandom_range(0, 4));
            a  = 16'($urandom);
            b  = 16'($urandom);
            c  = 16'($urandom);
            if (id >= 3) b = 16'($urandom_range(0, 40));
            if (id == 1 && $urandom_range(0, 2) == 0) a = 16'hFFFF;
            if (id == 3 && $urandom_range(0, 1) == 0) a = 16'hFFFF - 16'($urandom_range(0, 30));
            do_op(id, a, b, c, $sformatf("rand%0d_id%0d", i, id));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
